scroll_ctrl: RTL and testbench

Sequencing controller for the four-digit "dE10" character display. Holds a 2-bit rotation offset and advances it automatically on a prescaled tick, or on a manual step. Emits the four 2-bit character codes for HEX3..HEX0 (00=d, 01=E, 10=1, 11=0), which drive the existing per-digit character decoders. Replaces the switch-selected rotation with a timed scroll.

---
 rtl/scroll_ctrl.sv | 116 +++++++++++
 tb/tb_scroll_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_ctrl.sv
// scroll_ctrl
// Sequencing controller for the four-digit "dE10" character display.
// A 2-bit rotation offset advances on a prescaled tick while running, or on a
// manual step while holding. The four per-digit character codes are derived
// combinationally from the offset (00=d, 01=E, 10=1, 11=0).
//
// Optional feature macro: SCROLL_DIR_EN
//   defined   -> 'dir' port exists; dir=1 makes every advance -1 mod 4
//   undefined -> no 'dir' port; every advance is +1 mod 4
//
// Parameters:
//   TICK_COUNT : clock cycles per automatic advance (>= 2)
//   CW         : prescaler width, 2**CW >= TICK_COUNT
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   run      in   level, 1 = automatic scroll, 0 = hold
//   step     in   advance one position while holding
//   load     in   load 'start' into the offset (wins over any advance)
//   start    in   [1:0] value used by load
//   dir      in   (SCROLL_DIR_EN only) 0 = +1, 1 = -1 per advance
//   offset   out  [1:0] current rotation offset
//   c3..c0   out  [1:0] codes for HEX3..HEX0 = offset+0..offset+3 mod 4
//   tick     out  one-cycle pulse aligned with an offset produced by an advance
//   running  out  high while the controller is in RUN
module scroll_ctrl #(
  parameter int TICK_COUNT = 50000000,
  parameter int CW         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       load,
  input  logic [1:0] start,
`ifdef SCROLL_DIR_EN
  input  logic       dir,
`endif
  output logic [1:0] offset,
  output logic [1:0] c3,
  output logic [1:0] c2,
  output logic [1:0] c1,
  output logic [1:0] c0,
  output logic       tick,
  output logic       running
);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    offset_next;
  logic [1:0]    delta;
  logic          tick_next;
  logic          terminal;
  logic          advance;

  // Next-state, prescaler and offset update. Load outranks any advance and
  // suppresses the tick; step only counts while holding.
  always_comb begin
    state_next  = run ? RUN : HOLD;
    terminal    = (state == RUN) && (cnt == CW'(TICK_COUNT - 1));
    advance     = (state == RUN) ? terminal : step;
    cnt_next    = cnt + CW'(1);
    offset_next = offset;
    tick_next   = 1'b0;
`ifdef SCROLL_DIR_EN
    delta       = dir ? 2'b11 : 2'b01;
`else
    delta       = 2'b01;
`endif

    // The prescaler restarts on any state change so re-entering RUN always
    // waits a full period before the first automatic advance.
    if ((state != RUN) || (state_next != state) || load || terminal) begin
      cnt_next = '0;
    end

    if (load) begin
      offset_next = start;
    end else if (advance) begin
      offset_next = offset + delta;
      tick_next   = 1'b1;
    end
  end

  // State register, prescaler, offset and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HOLD;
      cnt     <= '0;
      offset  <= 2'b00;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      offset  <= offset_next;
      tick    <= tick_next;
      running <= (state_next == RUN);
    end
  end

  // Character codes follow the offset directly, so reset shows them at once.
  assign c3 = offset;
  assign c2 = offset + 2'd1;
  assign c1 = offset + 2'd2;
  assign c0 = offset + 2'd3;

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl
// Directed bench for scroll_ctrl with a short prescale period (TICK_COUNT=4).
// Stimulus pushes the expected (cycle, offset) of every tick into a
// scoreboard; a monitor pops and compares each time the DUT raises tick.
module tb_scroll_ctrl;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       run   = 1'b0;
  logic       step  = 1'b0;
  logic       load  = 1'b0;
  logic [1:0] start = 2'b00;
`ifdef SCROLL_DIR_EN
  logic       dir   = 1'b0;
`endif
  logic [1:0] offset;
  logic [1:0] c3;
  logic [1:0] c2;
  logic [1:0] c1;
  logic [1:0] c0;
  logic       tick;
  logic       running;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [1:0] off;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  scroll_ctrl #(
    .TICK_COUNT(4),
    .CW(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .step(step),
    .load(load),
    .start(start),
`ifdef SCROLL_DIR_EN
    .dir(dir),
`endif
    .offset(offset),
    .c3(c3),
    .c2(c2),
    .c1(c1),
    .c0(c0),
    .tick(tick),
    .running(running)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Edge counter used to timestamp expected and observed ticks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] codes_of(input logic [1:0] off);
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    a = off + 2'd1;
    b = off + 2'd2;
    c = off + 2'd3;
    return {off, a, b, c};
  endfunction

  task automatic expect_tick(input int c, input logic [1:0] off);
    exp_t e;
    e.cyc = c;
    e.off = off;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic l,
                                input logic [1:0] st);
    run   = r;
    step  = s;
    load  = l;
    start = st;
  endtask

  // Monitor: every tick must match the oldest scoreboard entry in both
  // timing and offset, and the digit codes must follow that offset.
  always @(negedge clk) begin
    if (!rst && tick) begin
      if (sb.size() == 0) begin
        check_output("unexpected_tick", {30'd0, offset}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check_output("tick_cycle", cyc, mon_e.cyc);
        check_output("tick_offset", {30'd0, offset}, {30'd0, mon_e.off});
        check_output("tick_codes", {24'd0, c3, c2, c1, c0},
                     {24'd0, codes_of(mon_e.off)});
      end
    end
  end

  // Directed sequence of scenarios.
  initial begin
    int k;
    int p;
    int q;

    repeat (2) @(negedge clk);
    check_output("reset_offset", {30'd0, offset}, 32'd0);
    check_output("reset_running", {31'd0, running}, 32'd0);
    check_output("reset_tick", {31'd0, tick}, 32'd0);
    check_output("reset_codes", {24'd0, c3, c2, c1, c0}, 32'h1B);
    rst = 1'b0;

    // Automatic scroll through a full wrap.
    k = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
    expect_tick(k + 5, 2'd1);
    expect_tick(k + 9, 2'd2);
    expect_tick(k + 13, 2'd3);
    expect_tick(k + 17, 2'd0);
    @(negedge clk);
    check_output("running_rise", {31'd0, running}, 32'd1);
    wait_cyc(k + 10);
    check_output("offset_two", {30'd0, offset}, 32'd2);
    check_output("codes_at_two", {24'd0, c3, c2, c1, c0}, 32'hB1);
    wait_cyc(k + 18);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("running_fall", {31'd0, running}, 32'd0);

    // Step pulses while holding, then step held high for three cycles.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00);
      expect_tick(cyc + 1, 2'(i + 1));
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
    end
    check_output("after_steps", {30'd0, offset}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00);
    expect_tick(cyc + 1, 2'd2);
    expect_tick(cyc + 2, 2'd3);
    expect_tick(cyc + 3, 2'd0);
    repeat (3) @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("after_held_step", {30'd0, offset}, 32'd0);

    // Load collides with a terminal count.
    p = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
    wait_cyc(p + 4);
    apply_stimulus(1'b1, 1'b0, 1'b1, 2'b10);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
    check_output("load_offset", {30'd0, offset}, 32'd2);
    check_output("load_no_tick", {31'd0, tick}, 32'd0);
    expect_tick(p + 9, 2'd3);
    wait_cyc(p + 9);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("load_running_fall", {31'd0, running}, 32'd0);

    // Run drops mid-count, then re-enters; run falls on the terminal edge.
    q = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
    wait_cyc(q + 3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    wait_cyc(q + 10);
    check_output("midcount_hold", {30'd0, offset}, 32'd3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
    expect_tick(q + 15, 2'd0);
    wait_cyc(q + 14);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("fall_on_terminal_running", {31'd0, running}, 32'd0);
    check_output("fall_on_terminal_offset", {30'd0, offset}, 32'd0);
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of a run at offset 3.
    apply_stimulus(1'b0, 1'b0, 1'b1, 2'b11);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
    check_output("hold_load_offset", {30'd0, offset}, 32'd3);
    check_output("hold_load_no_tick", {31'd0, tick}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("async_offset", {30'd0, offset}, 32'd0);
    check_output("async_running", {31'd0, running}, 32'd0);
    check_output("async_codes", {24'd0, c3, c2, c1, c0}, 32'h1B);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    repeat (6) @(negedge clk);
    check_output("post_reset_offset", {30'd0, offset}, 32'd0);

`ifdef SCROLL_DIR_EN
    // Reverse direction, automatic and stepped.
    dir = 1'b1;
    k = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
    expect_tick(k + 5, 2'd3);
    expect_tick(k + 9, 2'd2);
    expect_tick(k + 13, 2'd1);
    expect_tick(k + 17, 2'd0);
    wait_cyc(k + 18);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00);
    expect_tick(cyc + 1, 2'd3);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check_output("dir_step_offset", {30'd0, offset}, 32'd3);
    dir = 1'b0;
`endif

    // Give any late ticks a bounded window, then require an empty scoreboard.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check_output("pending_ticks", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
